// File: rtl/eval_sched_pkg.sv
// Shared types and helpers for the RTLola evaluation scheduler.
package eval_sched_pkg;
  localparam int MAX_OUT  = 64;
  localparam int MAX_LW   = 8;
  localparam int LOF_W    = MAX_OUT * MAX_LW;
  localparam int LOF_AW   = $clog2(LOF_W);
  localparam int TS_MAX_W = 64;

  typedef struct packed {
    logic                in_flag;
    logic                per_flag;
    logic [63:0]         data;
    logic [TS_MAX_W-1:0] ts;
  } event_t;

  typedef enum logic {IDLE, EVAL} sched_state_t;

  // Outputs whose lw-bit slice of layer_of equals lyr; bits above n_out stay 0.
  function automatic logic [MAX_OUT-1:0] layer_mask(input logic [LOF_W-1:0] layer_of,
                                                    input int n_out, input int lw, input int lyr);
    logic [MAX_OUT-1:0] m;
    int f;
    m = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      f = 0;
      for (int b = 0; b < MAX_LW; b++)
        if (i < n_out && b < lw && layer_of[LOF_AW'(i * lw + b)]) f = f | (1 << b);
      m[i] = (i < n_out) && (f == lyr);
    end
    return m;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// Circular buffer of event records; a push into a full queue succeeds when a pop happens alongside it.
module event_fifo
  import eval_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  event_t din,
  output event_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  event_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == FULL_CNT;
  assign empty   = cnt_q == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/eval_scheduler.sv
// Timestamps input/periodic events, queues them and walks each through the evaluation layers.
// Optional EVAL_SCHED_BYPASS_EN: an event arriving idle with an empty queue skips the queue.
module eval_scheduler
  import eval_sched_pkg::*;
#(
  parameter int NUM_OUTPUTS   = 9,
  parameter int NUM_LAYERS    = 4,
  parameter int QUEUE_DEPTH   = 8,
  parameter int PERIOD_CYCLES = 1000,
  parameter int TS_W          = 32,
  parameter logic [NUM_OUTPUTS-1:0] INPUT_PACED_MASK = NUM_OUTPUTS'('h0FF),
  parameter logic [NUM_OUTPUTS-1:0] PERIODIC_MASK    = NUM_OUTPUTS'('h100),
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter logic [NUM_OUTPUTS*LW-1:0] LAYER_OF = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   new_input,
  input  logic [63:0]            input_data,
  output logic                   q_push,
  output logic                   q_push_valid,
  output logic                   q_pop,
  output logic                   q_pop_valid,
  output logic [NUM_OUTPUTS-1:0] pacing,
  output logic [LW-1:0]          layer,
  output logic [63:0]            eval_data,
  output logic [TS_W-1:0]        eval_ts,
  output logic                   busy,
  output logic                   overflow
);
  localparam int PCW = $clog2(PERIOD_CYCLES);
  localparam logic [PCW-1:0] RELOAD     = PCW'(PERIOD_CYCLES - 1);
  localparam logic [LW-1:0]  LAST_LAYER = LW'(NUM_LAYERS - 1);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PCW-1:0]   per_cnt_q, per_cnt_d;
  logic             overflow_q, overflow_d;
  sched_state_t     state_q;
  logic [LW-1:0]    layer_q;
  event_t           cur_q, rec, fifo_dout;
  logic             run, per_tick, ev, idle, bypass, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MAX_OUT-1:0]     lmask;
  logic [NUM_OUTPUTS-1:0] fmask;
  logic                   unused_bits;

  // Gating with rst keeps the combinational strobes at 0 while reset is held.
  assign run      = en & rst;
  assign per_tick = per_cnt_q == '0;
  assign ev       = run & (new_input | per_tick);
  assign idle     = state_q == IDLE;

  always_comb begin
    rec          = '0;
    rec.in_flag  = new_input;
    rec.per_flag = per_tick;
    rec.data     = new_input ? input_data : 64'd0;
    rec.ts       = TS_MAX_W'(ts_q);
  end

`ifdef EVAL_SCHED_BYPASS_EN
  assign bypass = ev & idle & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push    = ev & ~bypass;
  assign fifo_pop     = run & idle & ~fifo_empty;
  assign q_push       = ev;
  assign q_push_valid = bypass | (fifo_push & (~fifo_full | fifo_pop));
  assign q_pop        = fifo_pop | bypass;
  assign q_pop_valid  = q_pop;

  event_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(fifo_push), .pop(fifo_pop), .din(rec),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    ts_d       = ts_q;
    per_cnt_d  = per_cnt_q;
    overflow_d = overflow_q | (ev & ~q_push_valid);
    if (run) begin
      ts_d      = ts_q + 1'b1;
      per_cnt_d = per_tick ? RELOAD : per_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      per_cnt_q  <= RELOAD;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      per_cnt_q  <= per_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      cur_q   <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: if (q_pop) begin
          cur_q   <= bypass ? rec : fifo_dout;
          layer_q <= '0;
          state_q <= EVAL;
        end
        EVAL: if (layer_q == LAST_LAYER) begin
          layer_q <= '0;
          state_q <= IDLE;
        end else begin
          layer_q <= layer_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lmask = layer_mask(LOF_W'(LAYER_OF), NUM_OUTPUTS, LW, int'(layer_q));
  assign fmask = (cur_q.in_flag ? INPUT_PACED_MASK : '0) | (cur_q.per_flag ? PERIODIC_MASK : '0);
  assign pacing = (run && state_q == EVAL) ? (fmask & lmask[NUM_OUTPUTS-1:0]) : '0;

  assign layer       = layer_q;
  assign eval_data   = cur_q.data;
  assign eval_ts     = cur_q.ts[TS_W-1:0];
  assign busy        = state_q == EVAL;
  assign overflow    = overflow_q;
  assign unused_bits = ^{lmask, cur_q.ts};
endmodule

// File: tb/tb_eval_scheduler.sv
// Directed bench for eval_scheduler; outputs 0..8 sit in layer i%4, output 8 is periodic.
module tb_eval_scheduler;
  localparam int NO = 9, NL = 4, QD = 8, PC = 1000, TW = 32;
  localparam logic [17:0] LOF = 18'h0E4E4;
`ifdef EVAL_SCHED_BYPASS_EN
  localparam int LAT = 0;
  localparam int DROP_K = 11;
`else
  localparam int LAT = 1;
  localparam int DROP_K = 10;
`endif

  logic clk, rst, en, new_input;
  logic [63:0] input_data;
  logic q_push, q_push_valid, q_pop, q_pop_valid, busy, overflow;
  logic [NO-1:0] pacing;
  logic [1:0] layer;
  logic [63:0] eval_data;
  logic [TW-1:0] eval_ts;

  int errors = 0, checks = 0, cyc = 0;
  logic [8:0] in_pace   [4] = '{9'h011, 9'h022, 9'h044, 9'h088};
  logic [8:0] both_pace [4] = '{9'h111, 9'h022, 9'h044, 9'h088};

  eval_scheduler #(.NUM_OUTPUTS(NO), .NUM_LAYERS(NL), .QUEUE_DEPTH(QD), .PERIOD_CYCLES(PC),
                   .TS_W(TW), .INPUT_PACED_MASK(9'h0FF), .PERIODIC_MASK(9'h100), .LAYER_OF(LOF)) dut (
    .clk(clk), .rst(rst), .en(en), .new_input(new_input), .input_data(input_data),
    .q_push(q_push), .q_push_valid(q_push_valid), .q_pop(q_pop), .q_pop_valid(q_pop_valid),
    .pacing(pacing), .layer(layer), .eval_data(eval_data), .eval_ts(eval_ts),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task run_to(input int n);
    while (cyc < n) step();
  endtask

  // Cycle 0 is the cycle right after reset release; ts equals the cycle number.
  task reset_dut();
    rst = 1'b0; en = 1'b1; new_input = 1'b0; input_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    #1;
  endtask

  task test_reset();
    rst = 1'b0; en = 1'b1; new_input = 1'b1; input_data = 64'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q_push, q_push_valid, q_pop, q_pop_valid, busy, overflow} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000000",
                         {q_push, q_push_valid, q_pop, q_pop_valid, busy, overflow});
    end
    checks++;
    if ({pacing, layer} !== 11'b0) begin
      errors++; $display("FAIL reset_pacing_layer: got %h/%0d expected 0/0", pacing, layer);
    end
    checks++;
    if ({eval_data, eval_ts} !== 96'b0) begin
      errors++; $display("FAIL reset_eval: got %h/%h expected 0/0", eval_data, eval_ts);
    end
    reset_dut();
  endtask

  task test_single();
    reset_dut();
    run_to(10);
    new_input = 1'b1; input_data = 64'd1;
    #1;
    checks++;
    if ({q_push, q_push_valid, q_pop} !== {2'b11, LAT == 0}) begin
      errors++; $display("FAIL single_push: got %b expected %b", {q_push, q_push_valid, q_pop}, {2'b11, LAT == 0});
    end
    step();
    new_input = 1'b0; input_data = '0;
    #1;
    checks++;
    if ({q_pop, q_pop_valid, busy} !== ((LAT == 1) ? 3'b110 : 3'b001)) begin
      errors++; $display("FAIL single_pop_t1: got %b expected %b", {q_pop, q_pop_valid, busy},
                         (LAT == 1) ? 3'b110 : 3'b001);
    end
    for (int l = 0; l < NL; l++) begin
      run_to(11 + LAT + l);
      checks++;
      if (pacing !== in_pace[l] || layer !== 2'(l) || busy !== 1'b1) begin
        errors++; $display("FAIL single_layer%0d: got pacing %h layer %0d busy %b expected %h %0d 1",
                           l, pacing, layer, busy, in_pace[l], l);
      end
      checks++;
      if (eval_data !== 64'd1 || eval_ts !== 32'd10) begin
        errors++; $display("FAIL single_eval%0d: got %0d/%0d expected 1/10", l, eval_data, eval_ts);
      end
    end
    run_to(15 + LAT);
    checks++;
    if ({busy, pacing} !== 10'b0) begin
      errors++; $display("FAIL single_done: got busy %b pacing %h expected 0 0", busy, pacing);
    end
  endtask

  task test_periodic();
    int hits[$];
    reset_dut();
    while (cyc < 3005) begin
      if (q_push === 1'b1) hits.push_back(cyc);
      if (cyc == 1000 + LAT) begin
        checks++;
        if (pacing !== 9'h100 || eval_ts !== 32'd999 || eval_data !== 64'd0) begin
          errors++; $display("FAIL periodic_layer0: got %h/%0d/%0d expected 100/999/0", pacing, eval_ts, eval_data);
        end
      end
      if (cyc == 1001 + LAT) begin
        checks++;
        if (pacing !== 9'h000 || busy !== 1'b1) begin
          errors++; $display("FAIL periodic_layer1: got %h busy %b expected 000 1", pacing, busy);
        end
      end
      step();
    end
    checks++;
    if (hits.size() !== 3) begin
      errors++; $display("FAIL periodic_count: got %0d expected 3", hits.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (((i < hits.size()) ? hits[i] : -1) !== 999 + 1000 * i) begin
        errors++; $display("FAIL periodic_time%0d: got %0d expected %0d", i,
                           (i < hits.size()) ? hits[i] : -1, 999 + 1000 * i);
      end
    end
  endtask

  task test_coincide();
    int pops;
    reset_dut();
    run_to(999);
    new_input = 1'b1; input_data = 64'hFFFF_FFFF_FFFF_FFFB;
    #1;
    pops = int'(q_pop);
    checks++;
    if ({q_push, q_push_valid} !== 2'b11) begin
      errors++; $display("FAIL coincide_push: got %b expected 11", {q_push, q_push_valid});
    end
    step();
    new_input = 1'b0;
    while (cyc < 1012) begin
      pops += int'(q_pop);
      if (cyc >= 1000 + LAT && cyc < 1004 + LAT) begin
        checks++;
        if (pacing !== both_pace[cyc - 1000 - LAT] || eval_data !== 64'hFFFF_FFFF_FFFF_FFFB) begin
          errors++; $display("FAIL coincide_layer%0d: got %h/%h expected %h/fffffffffffffffb",
                             cyc - 1000 - LAT, pacing, eval_data, both_pace[cyc - 1000 - LAT]);
        end
      end
      step();
    end
    checks++;
    if (pops !== 1) begin
      errors++; $display("FAIL coincide_pops: got %0d expected 1", pops);
    end
  endtask

  // The FSM drains records during the burst, so the queue fills only near its end.
  task test_burst();
    int pops;
    pops = 0;
    reset_dut();
    run_to(10);
    for (int k = 0; k < 12; k++) begin
      new_input = 1'b1; input_data = 64'(100 + k);
      #1;
      checks++;
      if (q_push_valid !== (k != DROP_K)) begin
        errors++; $display("FAIL burst_accept%0d: got %b expected %b", k, q_push_valid, k != DROP_K);
      end
      checks++;
      if (overflow !== (k > DROP_K)) begin
        errors++; $display("FAIL burst_overflow%0d: got %b expected %b", k, overflow, k > DROP_K);
      end
      pops += int'(q_pop);
      step();
    end
    new_input = 1'b0;
    while (cyc < 100) begin
      pops += int'(q_pop);
      step();
    end
    checks++;
    if (pops !== 11) begin
      errors++; $display("FAIL burst_pops: got %0d expected 11", pops);
    end
    checks++;
    if ({overflow, busy} !== 2'b10) begin
      errors++; $display("FAIL burst_sticky: got %b expected 10", {overflow, busy});
    end
    checks++;
    if (eval_data !== 64'((DROP_K == 10) ? 111 : 110)) begin
      errors++; $display("FAIL burst_last_data: got %0d expected %0d", eval_data, (DROP_K == 10) ? 111 : 110);
    end
  endtask

  task test_reset_mid();
    int bad;
    reset_dut();
    for (int c = 10; c <= 13 + LAT; c++) begin
      run_to(c);
      new_input = (c < 14); input_data = 64'(200 + c);
    end
    #1;
    checks++;
    if ({layer, busy} !== 3'b101) begin
      errors++; $display("FAIL mid_precond: got layer %0d busy %b expected 2 1", layer, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({q_push, q_push_valid, q_pop, q_pop_valid, busy, overflow, pacing, layer} !== 17'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0",
                         {q_push, q_push_valid, q_pop, q_pop_valid, busy, overflow, pacing, layer});
    end
    checks++;
    if ({eval_data, eval_ts} !== 96'b0) begin
      errors++; $display("FAIL mid_reset_eval: got %h/%h expected 0/0", eval_data, eval_ts);
    end
    new_input = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    #1;
    bad = 0;
    while (cyc < 30) begin
      if (q_pop !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL mid_flushed: got %0d cycles with pop/busy expected 0", bad);
    end
    new_input = 1'b1; input_data = 64'd7;
    step();
    new_input = 1'b0;
    #1;
    checks++;
    if ({q_pop, busy} !== ((LAT == 1) ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL mid_new_pop: got %b expected %b", {q_pop, busy}, (LAT == 1) ? 2'b10 : 2'b01);
    end
    run_to(31 + LAT);
    checks++;
    if (pacing !== 9'h011 || eval_ts !== 32'd30 || eval_data !== 64'd7) begin
      errors++; $display("FAIL mid_new_eval: got %h/%0d/%0d expected 011/30/7", pacing, eval_ts, eval_data);
    end
  endtask

  task test_enable();
    reset_dut();
    run_to(10);
    new_input = 1'b1; input_data = 64'd5;
    step();
    new_input = 1'b0;
    run_to(12);
    en = 1'b0;
    #1;
    checks++;
    if (pacing !== 9'h000 || busy !== 1'b1 || layer !== 2'(1 - LAT)) begin
      errors++; $display("FAIL en_low: got %h busy %b layer %0d expected 000 1 %0d", pacing, busy, layer, 1 - LAT);
    end
    repeat (5) step();
    checks++;
    if (layer !== 2'(1 - LAT) || busy !== 1'b1 || q_pop !== 1'b0) begin
      errors++; $display("FAIL en_hold: got layer %0d busy %b pop %b expected %0d 1 0", layer, busy, q_pop, 1 - LAT);
    end
    en = 1'b1;
    #1;
    checks++;
    if (pacing !== in_pace[1 - LAT]) begin
      errors++; $display("FAIL en_resume: got %h expected %h", pacing, in_pace[1 - LAT]);
    end
    step();
    checks++;
    if (layer !== 2'(2 - LAT) || pacing !== in_pace[2 - LAT]) begin
      errors++; $display("FAIL en_advance: got %0d/%h expected %0d/%h", layer, pacing, 2 - LAT, in_pace[2 - LAT]);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; new_input = 1'b0; input_data = '0;
    test_reset();
    test_single();
    test_periodic();
    test_coincide();
    test_burst();
    test_reset_mid();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
